ant_group_pingpong_buffer: RTL and testbench

Successor antenna-data re-sort buffer. It accepts NGRP sequential antenna-group blocks per symbol (ANT antennas x 32-bit IQ each) and stores them in double-buffered (ping-pong) RAM banks. Once all groups of a symbol are written, it replays them with every group in parallel at one RE per clock. Write of symbol n+1 overlaps read of symbol n. It sits between the FFT/IQ unpacker and the PUSCH dimension-reduction core, and drives the DR re-calculation clear flag with a programmable slot.

---
 rtl/ant_buf_pkg.sv | 46 ++++
 rtl/ant_group_pingpong_buffer_sdp_ram_lat.sv | 63 ++++++
 rtl/ant_group_pingpong_buffer.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_ant_group_pingpong_buffer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ant_buf_pkg.sv
// ---------------------------------------------------------------------------
// ant_buf_pkg
// Shared definitions for the antenna-group ping-pong re-sort buffer:
//   - IQ header field offsets (slot / symbol index inside i_info_0)
//   - DR re-calculation clear mode encoding
//   - read FSM state encoding
//   - dr_clear(): decides whether a symbol raises the DR clear pulse
// ---------------------------------------------------------------------------
package ant_buf_pkg;

  localparam int SLOT_LSB = 12;
  localparam int SLOT_W   = 7;
  localparam int SYMB_LSB = 8;
  localparam int SYMB_W   = 4;

  typedef enum logic [1:0] {
    DR_NEVER     = 2'b00,
    DR_SLOT_SYM0 = 2'b01,
    DR_SYM0      = 2'b10,
    DR_ALL       = 2'b11
  } dr_mode_e;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_RUN  = 1'b1
  } rd_state_e;

  // True when a symbol with the given slot/symbol index must clear the DR core.
  function automatic logic dr_clear(
    input logic [1:0]        mode,
    input logic [SLOT_W-1:0] clr_slot,
    input logic [SLOT_W-1:0] slot,
    input logic [SYMB_W-1:0] symb
  );
    logic res;
    case (dr_mode_e'(mode))
      DR_NEVER:     res = 1'b0;
      DR_SLOT_SYM0: res = (symb == {SYMB_W{1'b0}}) && (slot == clr_slot);
      DR_SYM0:      res = (symb == {SYMB_W{1'b0}});
      DR_ALL:       res = 1'b1;
      default:      res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ant_group_pingpong_buffer_sdp_ram_lat.sv
// ---------------------------------------------------------------------------
// sdp_ram_lat
// Simple dual-port RAM (one write port, one read port, same clock) with a
// parametric read latency. Read data appears LAT clocks after i_raddr is
// presented with i_re high. Each pipeline stage only loads when a valid read
// travels through it, so o_rdata holds the last read word between reads.
// RAM contents are not reset; only the read pipeline is.
// Ports:
//   i_clk, i_reset_n         clock, async active-low reset (read pipe only)
//   i_we, i_waddr, i_wdata   write port
//   i_re, i_raddr            read request
//   o_rdata                  registered read data
// ---------------------------------------------------------------------------
module sdp_ram_lat #(
  parameter int DW  = 128,
  parameter int AW  = 12,
  parameter int LAT = 2
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0]  mem_r [0:(2**AW)-1];
  logic [DW-1:0]  q_r   [0:LAT-1];
  logic [LAT-1:0] v_r;

  // Write port.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_r[i_waddr] <= i_wdata;
    end
  end

  // Read pipeline: stage 0 samples the array, later stages shift on valid only.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      v_r <= {LAT{1'b0}};
      for (int i = 0; i < LAT; i++) begin
        q_r[i] <= {DW{1'b0}};
      end
    end else begin
      v_r[0] <= i_re;
      if (i_re) begin
        q_r[0] <= mem_r[i_raddr];
      end
      for (int i = 1; i < LAT; i++) begin
        v_r[i] <= v_r[i-1];
        if (v_r[i-1]) begin
          q_r[i] <= q_r[i-1];
        end
      end
    end
  end

  assign o_rdata = q_r[LAT-1];

endmodule

// File: rtl/ant_group_pingpong_buffer.sv
// ---------------------------------------------------------------------------
// ant_group_pingpong_buffer
// Re-sorts NGRP sequential antenna-group blocks per symbol into one parallel
// stream. Groups are written into a ping-pong pair of banks; once all groups
// of a symbol are in, the bank is replayed with all groups side by side at
// one RE per clock while the next symbol fills the other bank.
// Ports:
//   i_clk, i_reset_n            clock, async active-low reset
//   i_dr_mode, i_clr_slot       DR clear policy (sampled at each output sop)
//   i_info_0, i_info_1          symbol header / per-group AGC
//   i_iq_addr/data/vld/last     input group-block beats
//   o_ant_data, o_ant_addr      output beat (group g at [g*ANT*32 +: ANT*32])
//   o_tvalid, o_ant_sop/eop     beat valid, first / last RE of symbol
//   o_info_0, o_info_1          header and AGCs of the symbol being output
//   o_slot_idx, o_symb_idx      header fields of o_info_0
//   o_symb_clr                  DR re-calculation clear pulse (with sop)
//   o_ovf                       pulse: incoming symbol dropped (both banks full)
//   o_level                     completed banks awaiting/under read (0..2)
// ---------------------------------------------------------------------------
module ant_group_pingpong_buffer
  import ant_buf_pkg::*;
#(
  parameter int ANT          = 4,
  parameter int NGRP         = 2,
  parameter int RE_NUM       = 1584,
  parameter int AW           = 11,
  parameter int READ_LATENCY = 2
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic [1:0]             i_dr_mode,
  input  logic [6:0]             i_clr_slot,
  input  logic [63:0]            i_info_0,
  input  logic [7:0]             i_info_1,
  input  logic [AW-1:0]          i_iq_addr,
  input  logic [ANT*32-1:0]      i_iq_data,
  input  logic                   i_iq_vld,
  input  logic                   i_iq_last,
  output logic [NGRP*ANT*32-1:0] o_ant_data,
  output logic [AW-1:0]          o_ant_addr,
  output logic                   o_tvalid,
  output logic                   o_ant_sop,
  output logic                   o_ant_eop,
  output logic [63:0]            o_info_0,
  output logic [NGRP*8-1:0]      o_info_1,
  output logic [6:0]             o_slot_idx,
  output logic [3:0]             o_symb_idx,
  output logic                   o_symb_clr,
  output logic                   o_ovf,
  output logic [1:0]             o_level
);

  localparam int DW  = ANT * 32;
  localparam int GW  = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam int LAT = READ_LATENCY;
  localparam logic [AW-1:0] RE_LAST  = AW'(RE_NUM - 1);
  localparam logic [AW:0]   RE_LIMIT = (AW+1)'(RE_NUM);
  localparam logic [GW-1:0] GRP_LAST = GW'(NGRP - 1);

  // ---------------- reset synchroniser ----------------
  logic [1:0] rst_sync_r;
  logic       rst_n_s;

  // Assert asynchronously, release two clocks after i_reset_n rises.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign rst_n_s = rst_sync_r[1];

  // ---------------- write side ----------------
  logic          wb_r;
  logic [GW-1:0] grp_r;
  logic          first_r;     // next valid beat opens a group block
  logic          drop_r;      // current symbol is being discarded
  logic [1:0]    level_r;
  logic          ovf_r;
  logic [63:0]   info_r [0:1];
  logic [7:0]    agc_r  [0:1][0:NGRP-1];

  logic          beat_first_s;
  logic          grp_last_s;
  logic          release_s;
  logic          drop_now_s;
  logic          drop_eff_s;
  logic          wrap_s;
  logic          complete_s;
  logic          in_range_s;
  logic [1:0]    level_nxt_s;
  logic [NGRP-1:0] we_s;

  // ---------------- read side ----------------
  rd_state_e     state_r;
  logic          rb_r;
  logic [AW-1:0] raddr_r;

  assign beat_first_s = i_iq_vld & first_r;
  assign grp_last_s   = (grp_r == GRP_LAST);
  assign release_s    = (state_r == RD_RUN) && (raddr_r == RE_LAST);
  // A symbol is refused at its very first beat if both banks are still
  // occupied and the reader is not freeing one in this same clock.
  assign drop_now_s   = beat_first_s && (grp_r == {GW{1'b0}}) &&
                        (level_r == 2'd2) && !release_s;
  assign drop_eff_s   = drop_r | drop_now_s;
  assign wrap_s       = i_iq_vld & i_iq_last & grp_last_s;
  assign complete_s   = wrap_s & ~drop_eff_s;
  assign in_range_s   = ({1'b0, i_iq_addr} < RE_LIMIT);
  assign level_nxt_s  = level_r + {1'b0, complete_s} - {1'b0, release_s};

  // Group counter, bank toggling, header capture, drop tracking and level.
  always_ff @(posedge i_clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      wb_r    <= 1'b0;
      grp_r   <= {GW{1'b0}};
      first_r <= 1'b1;
      drop_r  <= 1'b0;
      level_r <= 2'd0;
      ovf_r   <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        info_r[b] <= 64'd0;
        for (int g = 0; g < NGRP; g++) begin
          agc_r[b][g] <= 8'd0;
        end
      end
    end else begin
      if (i_iq_vld) begin
        first_r <= i_iq_last;
        if (beat_first_s && !drop_eff_s) begin
          if (grp_r == {GW{1'b0}}) begin
            info_r[wb_r] <= i_info_0;
          end
          agc_r[wb_r][grp_r] <= i_info_1;
        end
        if (i_iq_last) begin
          if (grp_last_s) begin
            grp_r  <= {GW{1'b0}};
            drop_r <= 1'b0;
            if (!drop_eff_s) begin
              wb_r <= ~wb_r;
            end
          end else begin
            grp_r  <= grp_r + GW'(1);
            drop_r <= drop_eff_s;
          end
        end else begin
          drop_r <= drop_eff_s;
        end
      end
      level_r <= level_nxt_s;
      ovf_r   <= drop_now_s;
    end
  end

  // Read FSM: sweeps raddr over bank rb, chaining banks without a bubble.
  always_ff @(posedge i_clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_r <= RD_IDLE;
      rb_r    <= 1'b0;
      raddr_r <= {AW{1'b0}};
    end else begin
      case (state_r)
        RD_IDLE: begin
          raddr_r <= {AW{1'b0}};
          if (level_r != 2'd0) begin
            state_r <= RD_RUN;
          end
        end
        RD_RUN: begin
          if (release_s) begin
            rb_r    <= ~rb_r;
            raddr_r <= {AW{1'b0}};
            if (level_nxt_s == 2'd0) begin
              state_r <= RD_IDLE;
            end
          end else begin
            raddr_r <= raddr_r + AW'(1);
          end
        end
        default: begin
          state_r <= RD_IDLE;
          raddr_r <= {AW{1'b0}};
        end
      endcase
    end
  end

  // ---------------- RAM: one bank pair per group ----------------
  for (genvar g = 0; g < NGRP; g++) begin : g_ram
    assign we_s[g] = i_iq_vld & ~drop_eff_s & in_range_s & (grp_r == GW'(g));

    sdp_ram_lat #(
      .DW  (DW),
      .AW  (AW + 1),
      .LAT (LAT)
    ) u_ram (
      .i_clk     (i_clk),
      .i_reset_n (rst_n_s),
      .i_we      (we_s[g]),
      .i_waddr   ({wb_r, i_iq_addr}),
      .i_wdata   (i_iq_data),
      .i_re      (state_r == RD_RUN),
      .i_raddr   ({rb_r, raddr_r}),
      .o_rdata   (o_ant_data[g*DW +: DW])
    );
  end

  // ---------------- output side-band pipeline ----------------
  logic           iss_vld_s;
  logic           iss_sop_s;
  logic           iss_eop_s;
  logic [LAT-1:0] p_vld_r;
  logic [LAT-1:0] p_sop_r;
  logic [LAT-1:0] p_eop_r;
  logic [LAT-1:0] p_bank_r;
  logic [AW-1:0]  p_addr_r [0:LAT-1];
  logic           nxt_sop_s;   // sop becomes visible on the next clock
  logic           nxt_bank_s;

  assign iss_vld_s = (state_r == RD_RUN);
  assign iss_sop_s = iss_vld_s && (raddr_r == {AW{1'b0}});
  assign iss_eop_s = release_s;

  // Delay beat qualifiers by the RAM read latency so they line up with data.
  always_ff @(posedge i_clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      p_vld_r  <= {LAT{1'b0}};
      p_sop_r  <= {LAT{1'b0}};
      p_eop_r  <= {LAT{1'b0}};
      p_bank_r <= {LAT{1'b0}};
      for (int i = 0; i < LAT; i++) begin
        p_addr_r[i] <= {AW{1'b0}};
      end
    end else begin
      p_vld_r[0]  <= iss_vld_s;
      p_sop_r[0]  <= iss_sop_s;
      p_eop_r[0]  <= iss_eop_s;
      p_bank_r[0] <= rb_r;
      p_addr_r[0] <= raddr_r;
      for (int i = 1; i < LAT; i++) begin
        p_vld_r[i]  <= p_vld_r[i-1];
        p_sop_r[i]  <= p_sop_r[i-1];
        p_eop_r[i]  <= p_eop_r[i-1];
        p_bank_r[i] <= p_bank_r[i-1];
        p_addr_r[i] <= p_addr_r[i-1];
      end
    end
  end

  if (LAT == 1) begin : g_nxt_issue
    assign nxt_sop_s  = iss_sop_s;
    assign nxt_bank_s = rb_r;
  end else begin : g_nxt_pipe
    assign nxt_sop_s  = p_sop_r[LAT-2];
    assign nxt_bank_s = p_bank_r[LAT-2];
  end

  logic [63:0]       info_out_r;
  logic [NGRP*8-1:0] agc_out_r;
  logic              clr_r;

  // Symbol metadata and DR clear are loaded so they change together with sop.
  always_ff @(posedge i_clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      info_out_r <= 64'd0;
      agc_out_r  <= {(NGRP*8){1'b0}};
      clr_r      <= 1'b0;
    end else if (nxt_sop_s) begin
      info_out_r <= info_r[nxt_bank_s];
      for (int g = 0; g < NGRP; g++) begin
        agc_out_r[g*8 +: 8] <= agc_r[nxt_bank_s][g];
      end
      clr_r <= dr_clear(i_dr_mode, i_clr_slot,
                        info_r[nxt_bank_s][SLOT_LSB +: SLOT_W],
                        info_r[nxt_bank_s][SYMB_LSB +: SYMB_W]);
    end else begin
      clr_r <= 1'b0;
    end
  end

  assign o_tvalid   = p_vld_r[LAT-1];
  assign o_ant_sop  = p_sop_r[LAT-1];
  assign o_ant_eop  = p_eop_r[LAT-1];
  assign o_ant_addr = p_addr_r[LAT-1];
  assign o_info_0   = info_out_r;
  assign o_info_1   = agc_out_r;
  assign o_slot_idx = info_out_r[SLOT_LSB +: SLOT_W];
  assign o_symb_idx = info_out_r[SYMB_LSB +: SYMB_W];
  assign o_symb_clr = clr_r;
  assign o_ovf      = ovf_r;
  assign o_level    = level_r;

endmodule

// File: tb/tb_ant_group_pingpong_buffer.sv
// ---------------------------------------------------------------------------
// Scoreboard bench for ant_group_pingpong_buffer (NGRP=2, RE_NUM=16).
// Stimulus pushes expected output beats into a queue as each accepted symbol
// completes; a negedge monitor pops and compares every o_tvalid beat.
// ---------------------------------------------------------------------------
module tb_ant_group_pingpong_buffer;

  localparam int ANT    = 4;
  localparam int NGRP   = 2;
  localparam int RE_NUM = 16;
  localparam int AW     = 5;
  localparam int LAT    = 2;
  localparam int DW     = ANT * 32;

  logic                   clk = 1'b0;
  logic                   i_reset_n;
  logic [1:0]             i_dr_mode;
  logic [6:0]             i_clr_slot;
  logic [63:0]            i_info_0;
  logic [7:0]             i_info_1;
  logic [AW-1:0]          i_iq_addr;
  logic [DW-1:0]          i_iq_data;
  logic                   i_iq_vld;
  logic                   i_iq_last;
  logic [NGRP*DW-1:0]     o_ant_data;
  logic [AW-1:0]          o_ant_addr;
  logic                   o_tvalid;
  logic                   o_ant_sop;
  logic                   o_ant_eop;
  logic [63:0]            o_info_0;
  logic [NGRP*8-1:0]      o_info_1;
  logic [6:0]             o_slot_idx;
  logic [3:0]             o_symb_idx;
  logic                   o_symb_clr;
  logic                   o_ovf;
  logic [1:0]             o_level;

  ant_group_pingpong_buffer #(
    .ANT(ANT), .NGRP(NGRP), .RE_NUM(RE_NUM), .AW(AW), .READ_LATENCY(LAT)
  ) dut (
    .i_clk(clk), .i_reset_n(i_reset_n), .i_dr_mode(i_dr_mode), .i_clr_slot(i_clr_slot),
    .i_info_0(i_info_0), .i_info_1(i_info_1), .i_iq_addr(i_iq_addr), .i_iq_data(i_iq_data),
    .i_iq_vld(i_iq_vld), .i_iq_last(i_iq_last), .o_ant_data(o_ant_data), .o_ant_addr(o_ant_addr),
    .o_tvalid(o_tvalid), .o_ant_sop(o_ant_sop), .o_ant_eop(o_ant_eop), .o_info_0(o_info_0),
    .o_info_1(o_info_1), .o_slot_idx(o_slot_idx), .o_symb_idx(o_symb_idx),
    .o_symb_clr(o_symb_clr), .o_ovf(o_ovf), .o_level(o_level)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NGRP*DW-1:0] data;
    logic [AW-1:0]      addr;
    logic               sop;
    logic               eop;
    logic               clr;
    logic [63:0]        info0;
    logic [NGRP*8-1:0]  info1;
    logic [6:0]         slot;
    logic [3:0]         symb;
  } exp_t;

  exp_t        exp_q [$];
  int          sop_q [$];
  logic [DW-1:0] mdl [0:1][0:NGRP-1][0:RE_NUM-1];
  int          n_chk  = 0;
  int          n_fail = 0;
  int          cyc    = 0;
  int          last_sop_cyc = 0;
  int          ovf_cnt = 0;
  int          max_lvl = 0;
  int          tb_wb   = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk_data(input int sym, input int g, input int n);
    logic [DW-1:0] w;
    for (int a = 0; a < ANT; a++) begin
      w[a*32 +: 32] = 32'h1000 * (g + 1) + n + (a << 8) + (sym << 16);
    end
    return w;
  endfunction

  function automatic logic [63:0] mk_info0(input int sym, input int slot, input int symb);
    return {16'hCAFE, 8'(sym), 8'h00, 13'h0000, 7'(slot), 4'(symb), 8'h5A};
  endfunction

  function automatic logic [7:0] mk_agc(input int sym, input int g);
    return 8'(sym * 16 + g + 1);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the scoreboard on every valid output beat.
  always @(negedge clk) begin
    exp_t e;
    if (int'(o_level) > max_lvl) max_lvl = int'(o_level);
    if (o_ovf) ovf_cnt++;
    if (o_tvalid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", {255'd0, o_tvalid}, 256'd0);
      end else begin
        e = exp_q.pop_front();
        chk("data",  o_ant_data, e.data);
        chk("addr",  o_ant_addr, e.addr);
        chk("sop",   o_ant_sop,  e.sop);
        chk("eop",   o_ant_eop,  e.eop);
        chk("clr",   o_symb_clr, e.clr);
        chk("info0", o_info_0,   e.info0);
        chk("info1", o_info_1,   e.info1);
        chk("slot",  o_slot_idx, e.slot);
        chk("symb",  o_symb_idx, e.symb);
      end
      if (o_ant_sop) begin
        last_sop_cyc = cyc;
        sop_q.push_back(cyc);
      end
      if (o_ant_eop) chk("frame_span", cyc - last_sop_cyc, RE_NUM - 1);
    end
  end

  task automatic drive_beat(input int addr, input logic [DW-1:0] data, input logic last,
                            input logic [63:0] info0, input logic [7:0] info1);
    @(negedge clk);
    i_iq_vld  = 1'b1;
    i_iq_addr = AW'(addr);
    i_iq_data = data;
    i_iq_last = last;
    i_info_0  = info0;
    i_info_1  = info1;
  endtask

  task automatic drive_idle();
    @(negedge clk);
    i_iq_vld  = 1'b0;
    i_iq_last = 1'b0;
    i_iq_addr = '1;
    i_iq_data = '1;
    i_info_0  = 64'hDEAD_DEAD_DEAD_DEAD;
    i_info_1  = 8'hEE;
  endtask

  // Writes one symbol (nbeats per group); headers are only correct on first beats.
  task automatic send_symbol(input int sym, input int slot, input int symb, input int nbeats,
                             input bit drop, input bit gaps, input bit bad, input bit clr);
    int bank;
    exp_t e;
    logic [63:0] inf;
    logic [DW-1:0] d;
    bank = tb_wb;
    inf  = mk_info0(sym, slot, symb);
    for (int g = 0; g < NGRP; g++) begin
      for (int n = 0; n < nbeats; n++) begin
        if (gaps) repeat ($urandom_range(0, 2)) drive_idle();
        d = mk_data(sym, g, n);
        drive_beat(n, d, (n == nbeats - 1) && !(bad && g == NGRP - 1),
                   (n == 0) ? inf : ~inf, (n == 0) ? mk_agc(sym, g) : ~mk_agc(sym, g));
        if (!drop) mdl[bank][g][n] = d;
      end
      if (bad && g == NGRP - 1) drive_beat(RE_NUM, '1, 1'b1, ~inf, ~mk_agc(sym, g));
    end
    if (!drop) begin
      for (int n = 0; n < RE_NUM; n++) begin
        for (int g = 0; g < NGRP; g++) begin
          e.data[g*DW +: DW] = mdl[bank][g][n];
          e.info1[g*8 +: 8]  = mk_agc(sym, g);
        end
        e.addr  = AW'(n);
        e.sop   = (n == 0);
        e.eop   = (n == RE_NUM - 1);
        e.clr   = clr && (n == 0);
        e.info0 = inf;
        e.slot  = 7'(slot);
        e.symb  = 4'(symb);
        exp_q.push_back(e);
      end
      tb_wb ^= 1;
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || o_tvalid) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    repeat (4) @(negedge clk);
    chk("drain_left", exp_q.size(), 0);
    chk("level_idle", o_level, 2'd0);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_data"}, o_ant_data, '0);
    chk({name, "_misc"}, {o_ant_addr, o_tvalid, o_ant_sop, o_ant_eop, o_info_0, o_info_1,
                          o_slot_idx, o_symb_idx, o_symb_clr, o_ovf, o_level}, '0);
  endtask

  logic [2:0] clr_tab [0:3];
  int k;
  int ovf0;

  initial begin
    for (int b = 0; b < 2; b++)
      for (int g = 0; g < NGRP; g++)
        for (int n = 0; n < RE_NUM; n++) mdl[b][g][n] = '0;
    clr_tab[0] = 3'b000; clr_tab[1] = 3'b010; clr_tab[2] = 3'b011; clr_tab[3] = 3'b111;
    i_reset_n = 1'b0; i_dr_mode = 2'b00; i_clr_slot = 7'd4;
    i_iq_vld = 1'b0; i_iq_last = 1'b0; i_iq_addr = '0; i_iq_data = '0;
    i_info_0 = '0; i_info_1 = '0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    i_reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk_reset_outputs("post_reset");

    // 1: single symbol, latency and level
    send_symbol(0, 4, 0, RE_NUM, 0, 0, 0, 0);
    drive_idle();
    chk("t1_level", o_level, 2'd1);
    k = 0;
    while (!o_tvalid && k < 20) begin @(negedge clk); k++; end
    chk("t1_latency", k, LAT + 1);
    drain();
    chk("t1_data_hold", o_ant_data, {mdl[0][1][RE_NUM-1], mdl[0][0][RE_NUM-1]});

    // 2: three symbols back-to-back
    ovf0 = ovf_cnt; max_lvl = 0;
    for (int s = 1; s <= 3; s++) send_symbol(s, 5, s, RE_NUM, 0, 0, 0, 0);
    drive_idle();
    drain();
    chk("t2_ovf", ovf_cnt - ovf0, 0);
    chk("t2_level_max", max_lvl, 1);

    // 3: fill both banks, third symbol dropped, fourth accepted
    ovf0 = ovf_cnt; max_lvl = 0; sop_q.delete();
    send_symbol(4, 6, 0, RE_NUM, 0, 0, 0, 0);
    send_symbol(5, 6, 1, 1, 0, 0, 0, 0);
    send_symbol(6, 6, 2, 1, 1, 0, 0, 0);
    drive_idle();
    drain();
    chk("t3_ovf", ovf_cnt - ovf0, 1);
    chk("t3_level_max", max_lvl, 2);
    chk("t3_frames", sop_q.size(), 2);
    if (sop_q.size() >= 2) chk("t3_no_bubble", sop_q[1] - sop_q[0], RE_NUM);
    send_symbol(7, 6, 3, RE_NUM, 0, 0, 0, 0);
    drive_idle();
    drain();

    // 4: DR clear modes
    for (int m = 0; m < 4; m++) begin
      logic [2:0] ct;
      i_dr_mode = 2'(m);
      ct = clr_tab[m];
      send_symbol(10 + 3*m, 3, 0, RE_NUM, 0, 0, 0, ct[0]);
      send_symbol(11 + 3*m, 4, 0, RE_NUM, 0, 0, 0, ct[1]);
      send_symbol(12 + 3*m, 4, 1, RE_NUM, 0, 0, 0, ct[2]);
      drive_idle();
      drain();
    end
    i_dr_mode = 2'b00;

    // 5: input gaps and an out-of-range closing beat
    send_symbol(30, 7, 2, RE_NUM, 0, 1, 1, 0);
    drive_idle();
    drain();

    // 6: reset in the middle of group 1, then a fresh symbol
    for (int n = 0; n < RE_NUM; n++) begin
      drive_beat(n, mk_data(40, 0, n), n == RE_NUM - 1, mk_info0(40, 9, 9), 8'h77);
      mdl[tb_wb][0][n] = mk_data(40, 0, n);
    end
    for (int n = 0; n < RE_NUM / 2; n++) begin
      drive_beat(n, mk_data(40, 1, n), 1'b0, mk_info0(40, 9, 9), 8'h78);
      mdl[tb_wb][1][n] = mk_data(40, 1, n);
    end
    drive_idle();
    i_reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("t6_in_reset");
    i_reset_n = 1'b1;
    tb_wb = 0;
    repeat (4) @(negedge clk);
    chk_reset_outputs("t6_after_reset");
    send_symbol(41, 2, 5, RE_NUM, 0, 0, 0, 0);
    drive_idle();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
